// File: rtl/instruction_fetch.sv
// Instruction prefetch unit: issues in-order word reads, buffers responses in a
// small FIFO, and handles branch redirects by discarding responses already in flight.
//
// state | meaning
// IDLE  | not fetching; waits for start
// RUN   | issuing requests under the credit limit and buffering responses
// FLUSH | after a redirect, dropping responses for requests issued before it

`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module instruction_fetch #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         start_pc,
  input  logic                          halt,
  input  logic                          redirect_valid,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc,
  output logic                          imem_req,
  output logic [ADDR_WIDTH-1:0]         imem_addr,
  input  logic                          imem_gnt,
  input  logic                          imem_rvalid,
  input  logic [`INSTRUCTION_WIDTH-1:0] imem_rdata,
  output logic [`INSTRUCTION_WIDTH-1:0] fetch_instruction,
  output logic                          fetch_valid,
  input  logic                          fetch_ready,
  output logic                          busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_SUM = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                        state, state_next;
  logic [ADDR_WIDTH-1:0]         pc, pc_next;
  logic [CW-1:0]                 fifo_count, outstanding, outstanding_next;
  logic [CW-1:0]                 discard, discard_next;
  logic [PW-1:0]                 rd_ptr, wr_ptr;
  logic [`INSTRUCTION_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                          grant, push, pop, flush;

  // Credit: buffered plus in-flight never exceeds the buffer size, so no overflow.
  always_comb begin
    imem_req = 1'b0;
    if (state == RUN && !halt && !redirect_valid &&
        ({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_SUM)
      imem_req = 1'b1;
  end

  assign imem_addr         = pc;
  assign fetch_valid       = (fifo_count != '0);
  assign fetch_instruction = fetch_valid ? mem[rd_ptr] : '0;
  assign busy              = (state != IDLE);

  assign grant = imem_req && imem_gnt;
  assign flush = redirect_valid && (state != IDLE);
  assign push  = (state == RUN) && imem_rvalid && !redirect_valid;
  assign pop   = fetch_valid && fetch_ready && !flush;

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    outstanding_next = outstanding;
    discard_next     = discard;
    case (state)
      IDLE: begin
        if (start) begin
          pc_next    = start_pc;
          state_next = RUN;
        end
      end
      RUN, FLUSH: begin
        if (redirect_valid) begin
          pc_next          = redirect_pc;
          outstanding_next = outstanding - CW'(imem_rvalid);
          discard_next     = outstanding_next;
          state_next       = (outstanding_next != '0) ? FLUSH : RUN;
        end else if (state == FLUSH) begin
          if (imem_rvalid) begin
            outstanding_next = outstanding - CW'(1);
            discard_next     = discard - CW'(1);
            if (discard == CW'(1))
              state_next = RUN;
          end
        end else begin
          outstanding_next = outstanding + CW'(grant) - CW'(imem_rvalid);
          if (grant)
            pc_next = pc + ADDR_WIDTH'(1);
          if (halt && outstanding == '0 && fifo_count == '0)
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      outstanding <= outstanding_next;
      discard     <= discard_next;
      if (flush) begin
        fifo_count <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: contents are only visible while fifo_count is nonzero.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= imem_rdata;
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_count == DEPTH_CNT))
    else $error("push into full prefetch buffer");
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: queue-based reference model checked every cycle,
// a simple in-order memory with programmable latency, and directed scenarios.

`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, redirect_valid, imem_gnt, imem_rvalid, fetch_ready;
  logic [15:0] start_pc, redirect_pc;
  logic        imem_req, fetch_valid, busy;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata, fetch_instruction;

  always #5 clk = ~clk;

  instruction_fetch #(.FIFO_DEPTH(4), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .fetch_instruction(fetch_instruction), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .busy(busy)
  );

  localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2;

  int          checks = 0, failures = 0;
  int          cyc = 0, mem_lat = 1;
  int          m_mode, m_inflight, m_discard;
  logic [15:0] m_pc;
  logic [31:0] m_fifo[$];
  bit          exp_ok = 0, exp_req, exp_valid, exp_busy;
  logic [15:0] exp_addr;
  logic [31:0] exp_instr;
  logic [15:0] pend_addr[$];
  int          pend_due[$];
  logic [15:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] out_log[$];

  function automatic logic [31:0] mdata(input logic [15:0] a);
    return {16'hC0DE, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (exp_ok && rst_n) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) chk("imem_addr", {16'b0, imem_addr}, {16'b0, exp_addr});
      chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, exp_valid});
      chk("fetch_instruction", fetch_instruction, exp_instr);
      chk("busy", {31'b0, busy}, {31'b0, exp_busy});
    end
  end

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 16'h0000; m_inflight = 0; m_discard = 0;
    m_fifo.delete();
  endtask

  task automatic model_update(input bit rv, input logic [31:0] rd);
    bit grant, pop;
    int old_n, old_inf;
    grant = exp_req && imem_gnt;
    pop   = exp_valid && fetch_ready;
    if (m_mode == M_IDLE) begin
      if (start) begin m_pc = start_pc; m_mode = M_RUN; end
    end else if (redirect_valid) begin
      m_fifo.delete();
      m_pc       = redirect_pc;
      m_inflight = m_inflight - int'(rv);
      m_discard  = m_inflight;
      m_mode     = (m_discard != 0) ? M_FLUSH : M_RUN;
    end else if (m_mode == M_FLUSH) begin
      if (rv) begin m_inflight--; m_discard--; end
      if (m_discard == 0) m_mode = M_RUN;
    end else begin
      old_n = m_fifo.size(); old_inf = m_inflight;
      if (pop) void'(m_fifo.pop_front());
      if (rv) m_fifo.push_back(rd);
      m_inflight = m_inflight + int'(grant) - int'(rv);
      if (grant) m_pc = m_pc + 16'h0001;
      if (halt && old_inf == 0 && old_n == 0) m_mode = M_IDLE;
    end
  endtask

  // One clock cycle: entered and left at posedge+1 with this cycle's inputs already set.
  task automatic tick();
    cyc++;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mdata(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    exp_busy  = (m_mode != M_IDLE);
    exp_req   = (m_mode == M_RUN) && !halt && !redirect_valid && (m_fifo.size() + m_inflight < 4);
    exp_addr  = m_pc;
    exp_valid = (m_fifo.size() != 0);
    exp_instr = exp_valid ? m_fifo[0] : 32'h0;
    exp_ok    = 1'b1;
    @(negedge clk); #1;
    if (imem_req && imem_gnt) begin
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + mem_lat);
      req_log.push_back(imem_addr);
      req_cyc.push_back(cyc);
    end
    if (fetch_valid && fetch_ready) out_log.push_back(fetch_instruction);
    model_update(imem_rvalid, imem_rdata);
    exp_ok = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    req_log.delete(); req_cyc.delete(); out_log.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, {31'b0, imem_req}, 32'h0);
    chk({tag, "_imem_addr"}, {16'b0, imem_addr}, 32'h0);
    chk({tag, "_fetch_valid"}, {31'b0, fetch_valid}, 32'h0);
    chk({tag, "_fetch_instr"}, fetch_instruction, 32'h0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 0; halt = 0; redirect_valid = 0; fetch_ready = 1; imem_gnt = 1;
    imem_rvalid = 0; imem_rdata = 32'h0; start_pc = 16'h0; redirect_pc = 16'h0;
    exp_ok = 0;
    pend_addr.delete(); pend_due.delete();
    model_reset();
    clear_logs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic start_at(input logic [15:0] pc);
    start_pc = pc; start = 1; tick(); start = 0;
  endtask

  initial begin
    int bad, n0, rcyc, idx;
    logic [31:0] tmp;

    rst_n = 1'b0; start = 0; halt = 0; redirect_valid = 0; fetch_ready = 1;
    imem_gnt = 1; imem_rvalid = 0; imem_rdata = 0; start_pc = 0; redirect_pc = 0;
    #2 chk_reset_outputs("reset0");

    // Straight-line fetch from 0x0010, 1-cycle memory.
    do_reset(); mem_lat = 1;
    start_at(16'h0010);
    repeat (12) tick();
    chk("s1_req0", {16'b0, req_log[0]}, 32'h0010);
    chk("s1_req1", {16'b0, req_log[1]}, 32'h0011);
    chk("s1_req2", {16'b0, req_log[2]}, 32'h0012);
    chk("s1_out0", out_log[0], 32'hC0DE0010);
    chk("s1_throughput", out_log.size(), 10);
    chk("s1_out9", out_log[9], 32'hC0DE0019);

    // Downstream stall for 10 cycles, then resume with a toggling grant.
    fetch_ready = 0;
    repeat (10) begin
      tick();
      chk("s2_head_stable", fetch_instruction, 32'hC0DE001A);
    end
    tmp = 32'(dut.fifo_count);
    chk("s2_fifo_full", tmp, 32'd4);
    chk("s2_req_dropped", {31'b0, imem_req}, 32'h0);
    fetch_ready = 1;
    for (int i = 0; i < 8; i++) begin
      imem_gnt = (i % 2 == 0);
      tick();
    end
    imem_gnt = 1;
    repeat (6) tick();
    bad = 0;
    for (int k = 0; k < out_log.size(); k++)
      if (out_log[k] !== mdata(16'h0010 + 16'(k))) bad++;
    chk("s2_order", bad, 0);
    chk("s2_enough_out", {31'b0, out_log.size() >= 16}, 32'h1);

    // Redirect with two requests in flight (3-cycle memory).
    do_reset(); mem_lat = 3;
    start_at(16'h0040);
    tick(); tick();
    redirect_valid = 1; redirect_pc = 16'h0100; rcyc = cyc + 1;
    tick();
    redirect_valid = 0;
    repeat (20) tick();
    idx = -1;
    for (int k = 0; k < req_cyc.size(); k++)
      if (idx < 0 && req_cyc[k] > rcyc) idx = k;
    if (idx < 0) chk("s3_req_timeout", 32'h0, 32'h1);
    else begin
      chk("s3_first_req_addr", {16'b0, req_log[idx]}, 32'h0100);
      chk("s3_flush_gap", req_cyc[idx] - rcyc, 3);
    end
    if (out_log.size() == 0) chk("s3_out_timeout", 32'h0, 32'h1);
    else chk("s3_first_out", out_log[0], 32'hC0DE0100);

    // Address wrap at the top of the space.
    do_reset(); mem_lat = 1;
    start_at(16'hFFFE);
    repeat (6) tick();
    chk("s4_req0", {16'b0, req_log[0]}, 32'hFFFE);
    chk("s4_req1", {16'b0, req_log[1]}, 32'hFFFF);
    chk("s4_req2", {16'b0, req_log[2]}, 32'h0000);
    chk("s4_out2", out_log[2], 32'hC0DE0000);

    // Halt with three buffered and one outstanding: drain all four, then IDLE.
    do_reset(); mem_lat = 1; fetch_ready = 0;
    start_at(16'h0200);
    repeat (4) tick();
    tmp = 32'(dut.fifo_count);
    chk("s5_buffered", tmp, 32'd3);
    tmp = 32'(dut.outstanding);
    chk("s5_outstanding", tmp, 32'd1);
    halt = 1; fetch_ready = 1; n0 = req_log.size();
    repeat (12) tick();
    chk("s5_delivered", out_log.size(), 4);
    chk("s5_out0", out_log[0], 32'hC0DE0200);
    chk("s5_out3", out_log[3], 32'hC0DE0203);
    chk("s5_busy", {31'b0, busy}, 32'h0);
    halt = 0; redirect_valid = 1; redirect_pc = 16'h0500;
    tick();
    redirect_valid = 0;
    repeat (3) tick();
    chk("s5_no_new_req", req_log.size() - n0, 0);
    chk("s5_idle_pc", {16'b0, imem_addr}, 32'h0204);

    // Reset while flushing two discards, then a clean restart.
    do_reset(); mem_lat = 3;
    start_at(16'h0300);
    tick(); tick();
    redirect_valid = 1; redirect_pc = 16'h0400;
    tick();
    redirect_valid = 0;
    tmp = 32'(dut.discard);
    chk("s6_discard", tmp, 32'd2);
    chk("s6_busy_flush", {31'b0, busy}, 32'h1);
    rst_n = 0;
    #1 chk_reset_outputs("s6_reset");
    do_reset(); mem_lat = 1;
    start_at(16'h0020);
    repeat (5) tick();
    chk("s6_restart_req", {16'b0, req_log[0]}, 32'h0020);
    chk("s6_restart_out", out_log[0], 32'hC0DE0020);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
